jalu_selftest: RTL

Autonomous self-test sequencer for the 8-bit jALU. It replaces the switch/button operand entry of the ALU demo with generated stimulus: it drives A, B, CI and OPS into a jALU instance and reads back its result and flags. It compares every response against a built-in model and reports the outcome on status outputs and on a 32-bit ASCII word for seven_seg_word. It sits beside the ALU on the demo board, with START fed from a click-debounced button.

---
 rtl/jalu_pkg.sv | 63 ++++++
 rtl/jalu_selftest_lfsr16.sv | 37 +++
 rtl/jalu_selftest.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/jalu_pkg.sv
// Shared definitions for the jALU self-test: opcodes, FSM states, corner vectors
// and the reference model used to judge every ALU response.
// Pure declarations; no clocked logic lives here.
package jalu_pkg;

  // jALU opcodes, swept in ascending order; opcode 7 is never exercised
  localparam logic [2:0] ADDR     = 3'd0;
  localparam logic [2:0] SHR      = 3'd1;
  localparam logic [2:0] SHL      = 3'd2;
  localparam logic [2:0] NOTR     = 3'd3;
  localparam logic [2:0] ANDR     = 3'd4;
  localparam logic [2:0] ORR      = 3'd5;
  localparam logic [2:0] XORR     = 3'd6;
  localparam logic [2:0] FIRST_OP = ADDR;
  localparam logic [2:0] LAST_OP  = XORR;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_FIN
  } state_e;

  // Corner vectors packed as {a, b, ci}; entry 0 is applied first
  localparam int NUM_CORNERS = 4;
  localparam logic [NUM_CORNERS-1:0][16:0] CORNER_VEC = {
    {8'h80, 8'h7F, 1'b1},
    {8'hFF, 8'h01, 1'b0},
    {8'hFF, 8'hFF, 1'b1},
    {8'h00, 8'h00, 1'b0}
  };

  // ASCII status words for seven_seg_word
  localparam logic [31:0] WORD_IDLE = 32'h69646C65; // "idle"
  localparam logic [31:0] WORD_RUN  = 32'h72756E20; // "run "
  localparam logic [31:0] WORD_PASS = 32'h70617373; // "pass"
  localparam logic [31:0] WORD_FAIL = 32'h6661696C; // "fail"

  // Expected ALU response, packed as {co, eqo, alo, z, out}
  function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic ci, input logic [2:0] ops);
    logic [8:0] sum;
    logic [7:0] out;
    logic       co;
    sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    out = 8'd0;
    co  = 1'b0;
    case (ops)
      ADDR: {co, out} = sum;
      SHR:  begin out = {ci, a[7:1]}; co = a[0]; end
      SHL:  begin out = {a[6:0], ci}; co = a[7]; end
      NOTR: out = ~a;
      ANDR: out = a & b;
      ORR:  out = a | b;
      XORR: out = a ^ b;
      default: out = 8'd0;
    endcase
    return {co, (a == b), (a > b), (out == 8'd0), out};
  endfunction

endpackage

// File: rtl/jalu_selftest_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) for demo stimulus generators.
// Latency: q_o reflects load/advance one cycle later.
// No backpressure: advances only on the cycle adv_i is high; load_i wins.
module lfsr16
  import jalu_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q, q_d;

  // Right-shifting Galois form: feedback bit folds into the tap mask
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = seed_i;
    end else if (adv_i) begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/jalu_selftest.sv
// Autonomous jALU self-test: sweeps corner + LFSR vectors over opcodes 0..6 and scores responses.
// Latency: 1 + 7*(4+VECTORS_PER_OP)*(SETTLE_CYCLES+2) + 1 cycles from START to DONE.
// No backpressure: START while BUSY is ignored. SELFTEST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module jalu_selftest
  import jalu_pkg::*;
#(
  parameter int          VECTORS_PER_OP = 64,
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic        CI,
  output logic [2:0]  OPS,
  input  logic [7:0]  ALU_OUT,
  input  logic        ALU_CO,
  input  logic        ALU_EQO,
  input  logic        ALU_ALO,
  input  logic        ALU_Z,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [7:0]  ERR_COUNT,
  output logic [2:0]  FAIL_OPS,
  output logic [7:0]  FAIL_A,
  output logic [7:0]  FAIL_B,
  output logic [31:0] WORD
);

  localparam logic [8:0] LAST_VEC   = 9'(NUM_CORNERS + VECTORS_PER_OP - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [8:0]  vec_q, vec_d;
  logic [3:0]  settle_q, settle_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        ci_q, ci_d;
  logic [2:0]  ops_q, ops_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [2:0]  fail_ops_q, fail_ops_d;
  logic [7:0]  fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [31:0] word_q, word_d;

  logic        lfsr_load, lfsr_adv;
  logic [15:0] lfsr_q;
  logic        mismatch, last_vec, last_op, stop_on_fail;

  lfsr16 #(.RESET_VAL(SEED)) u_lfsr (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .load_i (lfsr_load),
    .adv_i  (lfsr_adv),
    .seed_i (SEED),
    .q_o    (lfsr_q)
  );

  assign mismatch = alu_model(a_q, b_q, ci_q, ops_q) !=
                    {ALU_CO, ALU_EQO, ALU_ALO, ALU_Z, ALU_OUT};
  assign last_vec = (vec_q == LAST_VEC);
  assign last_op  = (op_q == LAST_OP);

`ifdef SELFTEST_STOP_ON_FAIL_EN
  assign stop_on_fail = mismatch;
`else
  assign stop_on_fail = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = S_LOAD;
      S_LOAD:   state_d = S_DRIVE;
      S_DRIVE:  state_d = S_SETTLE;
      S_SETTLE: if (settle_q == LAST_SETTLE) state_d = S_CHECK;
      S_CHECK:  state_d = (stop_on_fail || (last_vec && last_op)) ? S_FIN : S_DRIVE;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the stimulus, counters and result registers
  always_comb begin
    vec_d      = vec_q;
    settle_d   = settle_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    ci_d       = ci_q;
    ops_d      = ops_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_ops_d = fail_ops_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    word_d     = word_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = 8'd0;
          fail_ops_d = 3'd0;
          fail_a_d   = 8'd0;
          fail_b_d   = 8'd0;
          word_d     = WORD_RUN;
        end
      end
      S_LOAD: begin
        lfsr_load = 1'b1;
        op_d      = FIRST_OP;
        ops_d     = FIRST_OP;
        vec_d     = 9'd0;
      end
      S_DRIVE: begin
        ops_d    = op_q;
        settle_d = 4'd0;
        if (vec_q < 9'(NUM_CORNERS)) begin
          {a_d, b_d, ci_d} = CORNER_VEC[vec_q[1:0]];
        end else begin
          a_d      = lfsr_q[7:0];
          b_d      = lfsr_q[15:8];
          ci_d     = lfsr_q[0] ^ lfsr_q[15];
          lfsr_adv = 1'b1;
        end
      end
      S_SETTLE: settle_d = settle_q + 4'd1;
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (err_q == 8'd0) begin
            fail_ops_d = ops_q;
            fail_a_d   = a_q;
            fail_b_d   = b_q;
          end
        end
        if (last_vec) begin
          vec_d = 9'd0;
          if (!last_op) op_d = op_q + 3'd1;
        end else begin
          vec_d = vec_q + 9'd1;
        end
      end
      S_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_q == 8'd0);
        word_d = (err_q == 8'd0) ? WORD_PASS : WORD_FAIL;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vec_q      <= 9'd0;
      settle_q   <= 4'd0;
      op_q       <= 3'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      ci_q       <= 1'b0;
      ops_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 8'd0;
      fail_ops_q <= 3'd0;
      fail_a_q   <= 8'd0;
      fail_b_q   <= 8'd0;
      word_q     <= WORD_IDLE;
    end else begin
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ci_q       <= ci_d;
      ops_q      <= ops_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_ops_q <= fail_ops_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      word_q     <= word_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign CI        = ci_q;
  assign OPS       = ops_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERR_COUNT = err_q;
  assign FAIL_OPS  = fail_ops_q;
  assign FAIL_A    = fail_a_q;
  assign FAIL_B    = fail_b_q;
  assign WORD      = word_q;

endmodule
